// File: rtl/bitonic_sort_sched.sv
// Round-robin front end that shares one bitonic sorter among NREQ requesters.
// Captures the winner's vector, pulses the sorter, waits for done under a
// timeout and returns the sorted vector tagged with the requester index.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | no job; arbitrate req_i and capture the winner's vector
//   S_START | sort_en_o / gnt_o pulse, counter cleared
//   S_WAIT  | counting; done accepted once cnt >= 1, abort at TIMEOUT-1
//   S_RESP  | response held until rsp_ready_i, then rotate the pointer
module bitonic_sort_sched #(
   parameter int BITWIDTH = 8,
   parameter int ELEMENTS = 64,
   parameter int NREQ     = 4,
   parameter int TIMEOUT  = 4096,
   localparam int VW      = ELEMENTS * BITWIDTH,
   localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_i,
   input  logic [NREQ*VW-1:0]   data_i,
   output logic [NREQ-1:0]      gnt_o,
   output logic                 busy_o,
   output logic                 sort_en_o,
   output logic [VW-1:0]        sort_in_o,
   input  logic                 sort_done_i,
   input  logic [VW-1:0]        sort_out_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [IW-1:0]        rsp_id_o,
   output logic [VW-1:0]        rsp_data_o,
   output logic                 rsp_err_o
);

   localparam int CW = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [IW-1:0]   ptr;
   logic [IW-1:0]   id;
   logic [IW-1:0]   win;
   logic [IW-1:0]   idx;
   logic [CW-1:0]   cnt;
   logic            any_req;
   logic            done_ok;
   logic            tmo;

   assign any_req  = |req_i;
   // cnt == 0 filters a done left over from the previous job or a sorter reset
   assign done_ok  = sort_done_i && (cnt != '0);
   assign tmo      = (cnt == CW'(TIMEOUT - 1));
   assign rsp_id_o = id;

   // Round-robin pick: first set request at or above ptr, wrapping.
   always_comb begin
      win = '0;
      idx = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx = IW'((int'(ptr) + i) % NREQ);
         if (req_i[idx]) win = idx;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   // Next-state decode; done has priority over the timeout.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (any_req) state_nxt = S_START;
         S_START: state_nxt = S_WAIT;
         S_WAIT:  if (done_ok || tmo) state_nxt = S_RESP;
         S_RESP:  if (rsp_ready_i) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Control outputs decoded straight from the state register.
   always_comb begin
      busy_o      = (state != S_IDLE);
      sort_en_o   = (state == S_START);
      rsp_valid_o = (state == S_RESP);
   end

   // Datapath: capture, grant pulse, wait counter, response and pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr        <= '0;
         id         <= '0;
         cnt        <= '0;
         gnt_o      <= '0;
         sort_in_o  <= '0;
         rsp_data_o <= '0;
         rsp_err_o  <= 1'b0;
      end else begin
         gnt_o <= '0;
         case (state)
            S_IDLE: begin
               if (any_req) begin
                  sort_in_o <= data_i[win*VW +: VW];
                  id        <= win;
                  gnt_o     <= NREQ'(1) << win;
               end
            end
            S_START: cnt <= '0;
            S_WAIT: begin
               cnt <= cnt + CW'(1);
               if (done_ok) begin
                  rsp_data_o <= sort_out_i;
                  rsp_err_o  <= 1'b0;
               end else if (tmo) begin
                  rsp_data_o <= '0;
                  rsp_err_o  <= 1'b1;
               end
            end
            S_RESP: begin
               if (rsp_ready_i) ptr <= IW'((int'(id) + 1) % NREQ);
            end
            default: ;
         endcase
      end
   end

endmodule
